sb_rx_header_decoder: RTL and testbench

Sideband RX header decoder: receive-side counterpart of the TX header encoder. It takes the 62-bit sideband header delivered by the RX deserializer, plus the optional 64-bit data beat that follows it, and checks opcode, source/destination IDs and message code. It maps the message subcode back to the LTSM-level `{msg_no, msg_info}` encoding, interpreted in the context of the current LTSM state and sub-state, and presents a single-cycle decoded message to the LTSM.

---
 rtl/sb_msg_pkg.sv | 84 ++++++++
 rtl/sb_rx_subcode_lut.sv | 145 ++++++++++++++
 rtl/sb_rx_header_decoder.sv | 169 ++++++++++++++++
 tb/tb_sb_rx_header_decoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_msg_pkg.sv
// Sideband message definitions shared by the RX decoder and TX encoder.
// LTSM state codes, sub-states, opcodes, IDs and header field positions.
package sb_msg_pkg;

  localparam logic [3:0] ST_RESET         = 4'd0;
  localparam logic [3:0] ST_SBINIT        = 4'd2;
  localparam logic [3:0] ST_MBINIT        = 4'd3;
  localparam logic [3:0] ST_MBTRAIN       = 4'd4;
  localparam logic [3:0] ST_TRAINERROR_HS = 4'd7;
  localparam logic [3:0] ST_PHYRETRAIN    = 4'd10;

  localparam logic [3:0] SS_MBI_PARAM      = 4'd0;
  localparam logic [3:0] SS_MBI_CAL        = 4'd1;
  localparam logic [3:0] SS_MBI_REPAIRCLK  = 4'd2;
  localparam logic [3:0] SS_MBI_REPAIRVAL  = 4'd3;
  localparam logic [3:0] SS_MBI_REVERSALMB = 4'd4;
  localparam logic [3:0] SS_MBI_REPAIRMB   = 4'd5;

  localparam logic [3:0] SS_MBT_VALVREF     = 4'd0;
  localparam logic [3:0] SS_MBT_DATAVREF    = 4'd1;
  localparam logic [3:0] SS_MBT_SPEEDIDLE   = 4'd2;
  localparam logic [3:0] SS_MBT_TXSELFCAL   = 4'd3;
  localparam logic [3:0] SS_MBT_RXCLKCAL    = 4'd4;
  localparam logic [3:0] SS_MBT_VALTRAINCTR = 4'd5;
  localparam logic [3:0] SS_MBT_VALTRAINVREF= 4'd6;
  localparam logic [3:0] SS_MBT_DATATRAINC1 = 4'd7;
  localparam logic [3:0] SS_MBT_DATATRAINVR = 4'd8;
  localparam logic [3:0] SS_MBT_RXDESKEW    = 4'd9;
  localparam logic [3:0] SS_MBT_DATATRAINC2 = 4'd10;
  localparam logic [3:0] SS_MBT_LINKSPEED   = 4'd11;
  localparam logic [3:0] SS_MBT_REPAIR      = 4'd12;

  localparam logic [4:0] OP_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OP_MSG_DATA   = 5'b11011;

  localparam logic [2:0] SRCID = 3'b010;
  localparam logic [2:0] DSTID = 3'b110;

  localparam logic [1:0] TEST_TX_PT = 2'd0;
  localparam logic [1:0] TEST_RX_PT = 2'd2;

  localparam logic [3:0] NIB_TEST     = 4'h8;
  localparam logic [3:0] NIB_SBINIT   = 4'h9;
  localparam logic [3:0] NIB_MBINIT   = 4'hA;
  localparam logic [3:0] NIB_MBTRAIN  = 4'hB;
  localparam logic [3:0] NIB_PHYRETR  = 4'hC;
  localparam logic [3:0] NIB_TRAINERR = 4'hE;

  localparam logic [3:0] LO_ONE  = 4'h1;
  localparam logic [3:0] LO_REQ  = 4'h5;
  localparam logic [3:0] LO_RESP = 4'hA;

  localparam int HDR_OPC_LSB  = 0;
  localparam int HDR_OPC_MSB  = 4;
  localparam int HDR_CODE_LSB = 14;
  localparam int HDR_CODE_MSB = 21;
  localparam int HDR_SRC_LSB  = 29;
  localparam int HDR_SRC_MSB  = 31;
  localparam int HDR_SUB_LSB  = 32;
  localparam int HDR_SUB_MSB  = 39;
  localparam int HDR_INFO_LSB = 40;
  localparam int HDR_INFO_MSB = 55;
  localparam int HDR_DST_LSB  = 56;
  localparam int HDR_DST_MSB  = 58;

  typedef logic [4:0][7:0] sc_list_t;

  typedef struct packed {
    logic [3:0] no;
    logic [2:0] info;
    logic [3:0] st;
  } sb_msg_t;

  function automatic sc_list_t pack5(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d,
    input logic [7:0] e
  );
    pack5 = {e, d, c, b, a};
  endfunction

endpackage

// File: rtl/sb_rx_subcode_lut.sv
// Subcode list lookup: returns the 1-based position k of a subcode
// in the list selected by the msg_code state nibble and sub-state.
module sb_rx_subcode_lut
  import sb_msg_pkg::*;
(
  input  logic [7:0] msg_code,
  input  logic [7:0] subcode,
  input  logic [3:0] sub_state,
  input  logic       test_en,
  input  logic [1:0] test,
  output logic       hit,
  output logic [2:0] k
);

  sc_list_t   lst;
  logic [2:0] len;

  always_comb begin
    lst = '0;
    len = 3'd0;
    case (msg_code[7:4])
      NIB_SBINIT: begin
        lst = pack5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        len = 3'd1;
      end
      NIB_MBINIT: begin
        case (sub_state)
          SS_MBI_PARAM: begin
            lst = pack5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            len = 3'd1;
          end
          SS_MBI_CAL: begin
            lst = pack5(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
            len = 3'd1;
          end
          SS_MBI_REPAIRCLK: begin
            lst = pack5(8'h03, 8'h04, 8'h08, 8'h00, 8'h00);
            len = 3'd3;
          end
          SS_MBI_REPAIRVAL: begin
            lst = pack5(8'h09, 8'h0A, 8'h0C, 8'h00, 8'h00);
            len = 3'd3;
          end
          SS_MBI_REVERSALMB: begin
            lst = pack5(8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h00);
            len = 3'd4;
          end
          SS_MBI_REPAIRMB: begin
            lst = pack5(8'h11, 8'h13, 8'h14, 8'h00, 8'h00);
            len = 3'd3;
          end
          default: len = 3'd0;
        endcase
      end
      NIB_MBTRAIN: begin
        case (sub_state)
          SS_MBT_VALVREF: begin
            lst = pack5(8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_DATAVREF: begin
            lst = pack5(8'h02, 8'h03, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_SPEEDIDLE: begin
            lst = pack5(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
            len = 3'd1;
          end
          SS_MBT_TXSELFCAL: begin
            lst = pack5(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
            len = 3'd1;
          end
          SS_MBT_RXCLKCAL: begin
            lst = pack5(8'h06, 8'h07, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_VALTRAINCTR: begin
            lst = pack5(8'h08, 8'h09, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_VALTRAINVREF: begin
            lst = pack5(8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_DATATRAINC1: begin
            lst = pack5(8'h0C, 8'h0D, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_DATATRAINVR: begin
            lst = pack5(8'h0E, 8'h10, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_RXDESKEW: begin
            lst = pack5(8'h11, 8'h12, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_DATATRAINC2: begin
            lst = pack5(8'h13, 8'h14, 8'h00, 8'h00, 8'h00);
            len = 3'd2;
          end
          SS_MBT_LINKSPEED: begin
            lst = pack5(8'h15, 8'h16, 8'h17, 8'h18, 8'h19);
            len = 3'd5;
          end
          SS_MBT_REPAIR: begin
            lst = pack5(8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h00);
            len = 3'd4;
          end
          default: len = 3'd0;
        endcase
      end
      NIB_TRAINERR: begin
        lst = pack5(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        len = 3'd1;
      end
      NIB_PHYRETR: begin
        lst = pack5(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        len = 3'd1;
      end
      NIB_TEST: begin
        if (test_en && test == TEST_TX_PT) begin
          lst = pack5(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
          len = 3'd4;
        end else if (test_en && test == TEST_RX_PT) begin
          lst = pack5(8'h07, 8'h02, 8'h08, 8'h09, 8'h00);
          len = 3'd4;
        end
      end
      default: len = 3'd0;
    endcase
  end

  // Lists hold unique entries, so the first match is the only match.
  always_comb begin
    hit = 1'b0;
    k   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (!hit && 3'(i) < len && subcode == lst[i]) begin
        hit = 1'b1;
        k   = 3'(i + 1);
      end
    end
  end

endmodule

// File: rtl/sb_rx_header_decoder.sv
// Sideband RX header decoder: validates received headers, maps subcodes
// to LTSM {msg_no, msg_info} and pairs data headers with their beat.
module sb_rx_header_decoder #(
  parameter int CHECK_IDS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [61:0] i_header,
  input  logic        i_header_valid,
  input  logic [63:0] i_data,
  input  logic        i_data_valid,
  input  logic [3:0]  i_state,
  input  logic [3:0]  i_sub_state,
  input  logic        i_rx_point_sweep_test_en,
  input  logic [1:0]  i_rx_point_sweep_test,
  output logic        o_msg_valid,
  output logic [3:0]  o_msg_no,
  output logic [2:0]  o_msg_info,
  output logic [3:0]  o_msg_state,
  output logic [63:0] o_data,
  output logic        o_data_present,
  output logic        o_decode_error,
  output logic        o_busy
);

  import sb_msg_pkg::*;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [4:0]  opc;
  logic [7:0]  code;
  logic [7:0]  sub;
  logic [15:0] info;
  logic [2:0]  src;
  logic [2:0]  dst;
  logic [3:0]  hi;
  logic [3:0]  lo;

  assign opc  = i_header[HDR_OPC_MSB:HDR_OPC_LSB];
  assign code = i_header[HDR_CODE_MSB:HDR_CODE_LSB];
  assign src  = i_header[HDR_SRC_MSB:HDR_SRC_LSB];
  assign sub  = i_header[HDR_SUB_MSB:HDR_SUB_LSB];
  assign info = i_header[HDR_INFO_MSB:HDR_INFO_LSB];
  assign dst  = i_header[HDR_DST_MSB:HDR_DST_LSB];
  assign hi   = code[7:4];
  assign lo   = code[3:0];

  logic unused_hdr;
  assign unused_hdr = ^{i_header[61:59], i_header[28:22],
                        i_header[13:5], info[15:6], info[3]};

  logic       hit;
  logic [2:0] k;

  sb_rx_subcode_lut u_lut (
    .msg_code  (code),
    .subcode   (sub),
    .sub_state (i_sub_state),
    .test_en   (i_rx_point_sweep_test_en),
    .test      (i_rx_point_sweep_test),
    .hit       (hit),
    .k         (k)
  );

  logic    ids_ok;
  logic    op_nd;
  logic    op_d;
  logic    is_one;
  logic    is_req;
  logic    is_rsp;
  logic    nib_ok;
  logic    good;
  sb_msg_t dec;

  assign ids_ok = (CHECK_IDS == 0) ||
                  (src == SRCID && dst == DSTID);
  assign op_nd  = opc == OP_MSG_NODATA;
  assign op_d   = opc == OP_MSG_DATA;
  assign is_one = lo == LO_ONE && hi == NIB_SBINIT;
  assign is_req = lo == LO_REQ;
  assign is_rsp = lo == LO_RESP;
  assign good   = (op_nd | op_d) & ids_ok & nib_ok &
                  (is_one | ((is_req | is_rsp) & hit));

  always_comb begin
    dec    = '0;
    nib_ok = 1'b1;
    unique case (1'b1)
      hi == NIB_SBINIT:   dec.st = ST_SBINIT;
      hi == NIB_MBINIT:   dec.st = ST_MBINIT;
      hi == NIB_MBTRAIN:  dec.st = ST_MBTRAIN;
      hi == NIB_PHYRETR:  dec.st = ST_PHYRETRAIN;
      hi == NIB_TRAINERR: dec.st = ST_TRAINERROR_HS;
      hi == NIB_TEST: begin
        dec.st = i_state;
        nib_ok = i_rx_point_sweep_test_en;
      end
      default: nib_ok = 1'b0;
    endcase
    if (is_one)
      dec.no = 4'd3;
    else if (is_req)
      dec.no = {k, 1'b0} - 4'd1;
    else
      dec.no = {k, 1'b0};
    // TX-init point-test response carries its result in info[5:4]
    if (hi == NIB_TEST &&
        i_rx_point_sweep_test == TEST_TX_PT &&
        dec.no == 4'd6)
      dec.info = {1'b0, info[5:4]};
    else
      dec.info = info[2:0];
  end

  logic [0:0] state_q;
  sb_msg_t    pend_q;

  assign o_busy = state_q == S_WAIT;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      o_msg_valid    <= 1'b0;
      o_msg_no       <= '0;
      o_msg_info     <= '0;
      o_msg_state    <= '0;
      o_data         <= '0;
      o_data_present <= 1'b0;
      o_decode_error <= 1'b0;
    end else begin
      o_msg_valid    <= 1'b0;
      o_decode_error <= 1'b0;
      if (i_header_valid) begin
        // A header always wins; a pending data message is dropped.
        if (state_q == S_WAIT)
          o_decode_error <= 1'b1;
        if (!good) begin
          o_decode_error <= 1'b1;
          state_q        <= S_IDLE;
        end else if (op_d) begin
          pend_q  <= dec;
          state_q <= S_WAIT;
        end else begin
          o_msg_valid    <= 1'b1;
          o_msg_no       <= dec.no;
          o_msg_info     <= dec.info;
          o_msg_state    <= dec.st;
          o_data_present <= 1'b0;
          state_q        <= S_IDLE;
        end
      end else if (i_data_valid) begin
        if (state_q == S_WAIT) begin
          o_msg_valid    <= 1'b1;
          o_msg_no       <= pend_q.no;
          o_msg_info     <= pend_q.info;
          o_msg_state    <= pend_q.st;
          o_data         <= i_data;
          o_data_present <= 1'b1;
          state_q        <= S_IDLE;
        end else begin
          o_decode_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_rx_header_decoder.sv
// Self-checking bench for sb_rx_header_decoder: directed cases plus
// random headers against a message-level reference model.
module tb_sb_rx_header_decoder;

  import sb_msg_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [61:0] i_header;
  logic        i_header_valid;
  logic [63:0] i_data;
  logic        i_data_valid;
  logic [3:0]  i_state;
  logic [3:0]  i_sub_state;
  logic        i_rx_point_sweep_test_en;
  logic [1:0]  i_rx_point_sweep_test;
  logic        o_msg_valid;
  logic [3:0]  o_msg_no;
  logic [2:0]  o_msg_info;
  logic [3:0]  o_msg_state;
  logic [63:0] o_data;
  logic        o_data_present;
  logic        o_decode_error;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  sb_rx_header_decoder #(.CHECK_IDS(1)) dut (
    .i_clk                    (i_clk),
    .i_rst                    (i_rst),
    .i_header                 (i_header),
    .i_header_valid           (i_header_valid),
    .i_data                   (i_data),
    .i_data_valid             (i_data_valid),
    .i_state                  (i_state),
    .i_sub_state              (i_sub_state),
    .i_rx_point_sweep_test_en (i_rx_point_sweep_test_en),
    .i_rx_point_sweep_test    (i_rx_point_sweep_test),
    .o_msg_valid              (o_msg_valid),
    .o_msg_no                 (o_msg_no),
    .o_msg_info               (o_msg_info),
    .o_msg_state              (o_msg_state),
    .o_data                   (o_data),
    .o_data_present           (o_data_present),
    .o_decode_error           (o_decode_error),
    .o_busy                   (o_busy)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: message-level view of pending and emitted messages.
  bit          m_pend;
  int          p_no, p_info, p_st;
  bit          e_valid, e_err, e_dp;
  int          e_no, e_info, e_st;
  logic [63:0] e_data;

  function automatic int ref_entry(int hi, int ss, bit en, int tt, int i);
    int l[5];
    l = '{-1, -1, -1, -1, -1};
    case (hi)
      'h9: l = '{1, -1, -1, -1, -1};
      'hA: case (ss)
        0: l = '{'h00, -1, -1, -1, -1};
        1: l = '{'h02, -1, -1, -1, -1};
        2: l = '{'h03, 'h04, 'h08, -1, -1};
        3: l = '{'h09, 'h0A, 'h0C, -1, -1};
        4: l = '{'h0D, 'h0E, 'h0F, 'h10, -1};
        5: l = '{'h11, 'h13, 'h14, -1, -1};
        default: ;
      endcase
      'hB: case (ss)
        0:  l = '{'h00, 'h01, -1, -1, -1};
        1:  l = '{'h02, 'h03, -1, -1, -1};
        2:  l = '{'h04, -1, -1, -1, -1};
        3:  l = '{'h05, -1, -1, -1, -1};
        4:  l = '{'h06, 'h07, -1, -1, -1};
        5:  l = '{'h08, 'h09, -1, -1, -1};
        6:  l = '{'h0A, 'h0B, -1, -1, -1};
        7:  l = '{'h0C, 'h0D, -1, -1, -1};
        8:  l = '{'h0E, 'h10, -1, -1, -1};
        9:  l = '{'h11, 'h12, -1, -1, -1};
        10: l = '{'h13, 'h14, -1, -1, -1};
        11: l = '{'h15, 'h16, 'h17, 'h18, 'h19};
        12: l = '{'h1B, 'h1C, 'h1D, 'h1E, -1};
        default: ;
      endcase
      'hC: l = '{'h01, -1, -1, -1, -1};
      'hE: l = '{'h00, -1, -1, -1, -1};
      'h8: if (en) begin
        if (tt == 0) l = '{1, 2, 3, 4, -1};
        else if (tt == 2) l = '{7, 2, 8, 9, -1};
      end
      default: ;
    endcase
    return l[i];
  endfunction

  task automatic ref_dec(input logic [61:0] h, output bit bad,
                         output bit wd, output int no,
                         output int info, output int st);
    int hi, lo, sub, k, ss, tt;
    bit en;
    hi  = int'(h[21:18]);
    lo  = int'(h[17:14]);
    sub = int'(h[39:32]);
    ss  = int'(i_sub_state);
    tt  = int'(i_rx_point_sweep_test);
    en  = i_rx_point_sweep_test_en;
    bad = 0; wd = 0; no = 0; info = 0; st = 0;
    if (h[4:0] == 5'b11011) wd = 1;
    else if (h[4:0] != 5'b10010) bad = 1;
    if (h[31:29] != 3'b010 || h[58:56] != 3'b110) bad = 1;
    case (hi)
      'h9: st = 2;
      'hA: st = 3;
      'hB: st = 4;
      'hC: st = 10;
      'hE: st = 7;
      'h8: begin st = int'(i_state); if (!en) bad = 1; end
      default: bad = 1;
    endcase
    k = 0;
    for (int i = 0; i < 5; i++)
      if (k == 0 && ref_entry(hi, ss, en, tt, i) == sub) k = i + 1;
    if (lo == 1) begin
      no = 3;
      if (hi != 9) bad = 1;
    end else if (lo == 5) begin
      no = 2 * k - 1;
      if (k == 0) bad = 1;
    end else if (lo == 10) begin
      no = 2 * k;
      if (k == 0) bad = 1;
    end else bad = 1;
    info = (hi == 8 && tt == 0 && no == 6) ? int'(h[45:44])
                                            : int'(h[42:40]);
  endtask

  task automatic model_reset();
    m_pend = 0; p_no = 0; p_info = 0; p_st = 0;
    e_valid = 0; e_err = 0; e_dp = 0;
    e_no = 0; e_info = 0; e_st = 0; e_data = '0;
  endtask

  task automatic model_step();
    bit bad, wd;
    int no, info, st;
    e_valid = 0;
    e_err   = 0;
    if (i_header_valid) begin
      ref_dec(i_header, bad, wd, no, info, st);
      if (m_pend) e_err = 1;
      m_pend = 0;
      if (bad) e_err = 1;
      else if (wd) begin
        m_pend = 1; p_no = no; p_info = info; p_st = st;
      end else begin
        e_valid = 1; e_dp = 0;
        e_no = no; e_info = info; e_st = st;
      end
    end else if (i_data_valid) begin
      if (m_pend) begin
        e_valid = 1; e_dp = 1; e_data = i_data;
        e_no = p_no; e_info = p_info; e_st = p_st;
        m_pend = 0;
      end else e_err = 1;
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(o_msg_valid), 64'(e_valid));
    chk("error", 64'(o_decode_error), 64'(e_err));
    chk("busy", 64'(o_busy), 64'(m_pend));
    chk("msg_no", 64'(o_msg_no), 64'(e_no));
    chk("msg_info", 64'(o_msg_info), 64'(e_info));
    chk("msg_state", 64'(o_msg_state), 64'(e_st));
    if (e_valid) begin
      chk("data_present", 64'(o_data_present), 64'(e_dp));
      if (e_dp) chk("data", o_data, e_data);
    end
  endtask

  task automatic cyc(input bit hv, input logic [61:0] h,
                     input bit dv, input logic [63:0] d);
    i_header_valid = hv;
    i_header       = h;
    i_data_valid   = dv;
    i_data         = d;
    model_step();
    @(negedge i_clk);
    check_outputs();
    i_header_valid = 0;
    i_data_valid   = 0;
  endtask

  function automatic logic [61:0] mk_hdr(
    input logic [4:0] opc, input logic [7:0] code,
    input logic [7:0] sub, input logic [15:0] info,
    input logic [2:0] src, input logic [2:0] dst);
    logic [61:0] h;
    h        = '0;
    h[4:0]   = opc;
    h[21:14] = code;
    h[31:29] = src;
    h[39:32] = sub;
    h[55:40] = info;
    h[58:56] = dst;
    return h;
  endfunction

  initial begin
    logic [61:0] h;
    logic [3:0]  hi, lo;
    logic [4:0]  opc;
    logic [7:0]  sub;
    logic [2:0]  src, dst;
    bit          hv, dv;
    int          e;

    i_rst = 1; i_header = '0; i_header_valid = 0;
    i_data = '0; i_data_valid = 0; i_state = 0; i_sub_state = 0;
    i_rx_point_sweep_test_en = 0; i_rx_point_sweep_test = 0;
    model_reset();
    repeat (2) @(negedge i_clk);
    check_outputs();
    chk("rst_dp", 64'(o_data_present), 64'd0);
    chk("rst_data", o_data, 64'd0);
    i_rst = 0;

    // MBINIT/REPAIRVAL Req
    i_state = ST_MBINIT; i_sub_state = SS_MBI_REPAIRVAL;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'hA5, 8'h0A, 16'h0, SRCID, DSTID),
        0, '0);
    chk("tp1_valid", 64'(o_msg_valid), 64'd1);
    chk("tp1_no", 64'(o_msg_no), 64'd3);
    chk("tp1_state", 64'(o_msg_state), 64'd3);

    // SBINIT
    i_state = ST_SBINIT;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'h91, 8'h00, 16'h0, SRCID, DSTID),
        0, '0);
    chk("tp2a_no", 64'(o_msg_no), 64'd3);
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'h9A, 8'h01, 16'h0, SRCID, DSTID),
        0, '0);
    chk("tp2b_no", 64'(o_msg_no), 64'd2);
    chk("tp2b_state", 64'(o_msg_state), 64'd2);

    // TX-init point test response
    i_state = ST_MBTRAIN;
    i_rx_point_sweep_test_en = 1; i_rx_point_sweep_test = TEST_TX_PT;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'h8A, 8'h03, 16'h0030, SRCID, DSTID),
        0, '0);
    chk("tp3_no", 64'(o_msg_no), 64'd6);
    chk("tp3_info", 64'(o_msg_info), 64'd3);
    chk("tp3_state", 64'(o_msg_state), 64'd4);

    // Data message with three idle cycles before the beat
    i_state = ST_MBINIT; i_sub_state = SS_MBI_REPAIRCLK;
    cyc(1, mk_hdr(OP_MSG_DATA, 8'hAA, 8'h08, 16'h5, SRCID, DSTID),
        0, '0);
    chk("tp4_busy0", 64'(o_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 0, '0);
      chk("tp4_busy", 64'(o_busy), 64'd1);
    end
    cyc(0, '0, 1, 64'hDEAD_BEEF_0123_4567);
    chk("tp4_valid", 64'(o_msg_valid), 64'd1);
    chk("tp4_data", o_data, 64'hDEAD_BEEF_0123_4567);
    chk("tp4_dp", 64'(o_data_present), 64'd1);
    chk("tp4_no", 64'(o_msg_no), 64'd6);
    chk("tp4_busy_end", 64'(o_busy), 64'd0);

    // Header during WAIT_DATA preempts the pending message
    cyc(1, mk_hdr(OP_MSG_DATA, 8'hA5, 8'h03, 16'h1, SRCID, DSTID),
        0, '0);
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'hA5, 8'h04, 16'h2, SRCID, DSTID),
        1, 64'h1111);
    chk("tp5_err", 64'(o_decode_error), 64'd1);
    chk("tp5_valid", 64'(o_msg_valid), 64'd1);
    chk("tp5_no", 64'(o_msg_no), 64'd3);
    chk("tp5_dp", 64'(o_data_present), 64'd0);

    // Reset while waiting for data
    cyc(1, mk_hdr(OP_MSG_DATA, 8'hA5, 8'h03, 16'h1, SRCID, DSTID),
        0, '0);
    i_rst = 1;
    model_reset();
    @(negedge i_clk);
    check_outputs();
    i_rst = 0;
    cyc(0, '0, 0, '0);
    chk("tp6_novalid", 64'(o_msg_valid), 64'd0);
    cyc(0, '0, 1, 64'h2222);
    chk("tp6_stray_err", 64'(o_decode_error), 64'd1);
    chk("tp6_stray_valid", 64'(o_msg_valid), 64'd0);

    // Bad dstid, unknown subcode
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'hA5, 8'h03, 16'h0, SRCID, 3'b101),
        0, '0);
    chk("tp7_err", 64'(o_decode_error), 64'd1);
    chk("tp7_valid", 64'(o_msg_valid), 64'd0);
    i_state = ST_MBTRAIN; i_sub_state = SS_MBT_REPAIR;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'hB5, 8'h1A, 16'h0, SRCID, DSTID),
        0, '0);
    chk("tp8_err", 64'(o_decode_error), 64'd1);
    chk("tp8_valid", 64'(o_msg_valid), 64'd0);

    // LINKSPEED last entry and RX-init point test
    i_sub_state = SS_MBT_LINKSPEED;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'hBA, 8'h19, 16'h7, SRCID, DSTID),
        0, '0);
    chk("tp9_no", 64'(o_msg_no), 64'd10);
    i_rx_point_sweep_test = TEST_RX_PT;
    cyc(1, mk_hdr(OP_MSG_NODATA, 8'h85, 8'h07, 16'h6, SRCID, DSTID),
        0, '0);
    chk("tp10_no", 64'(o_msg_no), 64'd1);
    chk("tp10_info", 64'(o_msg_info), 64'd6);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      i_state = 4'($urandom);
      i_sub_state = ($urandom % 8 == 0) ? 4'($urandom)
                                        : 4'($urandom % 13);
      i_rx_point_sweep_test_en = 1'($urandom);
      i_rx_point_sweep_test = 2'($urandom);
      hv = ($urandom % 3) == 0;
      dv = hv ? (m_pend && ($urandom % 4) == 0) : (($urandom % 4) == 0);
      case ($urandom % 7)
        0: hi = 4'h9;
        1: hi = 4'hA;
        2: hi = 4'hB;
        3: hi = 4'hC;
        4: hi = 4'hE;
        5: hi = 4'h8;
        default: hi = 4'($urandom);
      endcase
      case ($urandom % 5)
        0: lo = 4'h1;
        1, 2: lo = 4'h5;
        3: lo = 4'hA;
        default: lo = 4'($urandom);
      endcase
      sub = 8'($urandom % 32);
      if ($urandom % 4 != 0) begin
        e = ref_entry(int'(hi), int'(i_sub_state),
                      i_rx_point_sweep_test_en,
                      int'(i_rx_point_sweep_test), int'($urandom % 5));
        if (e >= 0) sub = 8'(e);
      end
      case ($urandom % 8)
        0, 1, 2, 3: opc = OP_MSG_NODATA;
        4, 5, 6: opc = OP_MSG_DATA;
        default: opc = 5'($urandom);
      endcase
      src = ($urandom % 16 == 0) ? 3'($urandom) : SRCID;
      dst = ($urandom % 16 == 0) ? 3'($urandom) : DSTID;
      h = mk_hdr(opc, {hi, lo}, sub, 16'($urandom), src, dst);
      h[61:59] = 3'($urandom);
      h[13:5]  = 9'($urandom);
      cyc(hv, h, dv, {32'($urandom), 32'($urandom)});
    end
    repeat (2) cyc(0, '0, 0, '0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
